// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the generic inter-stage pipeline register.
// Holds the stage event encoding used by the register and its decoder.
package pipe_stage_reg_pkg;

    // Width of the encoded stage event bus
    localparam int unsigned EVT_W = 3;

    typedef enum logic [EVT_W-1:0] {
        EVT_RST    = 3'd0,
        EVT_FLUSH  = 3'd1,
        EVT_BUBBLE = 3'd2,
        EVT_HOLD   = 3'd3,
        EVT_ADV    = 3'd4
    } stage_evt_e;

    // Saturating increment of the bubble counter
    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] max
    );
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_stage_evt_decode.sv
// Priority decode of reset, flush and the local stall pair into one event.
// Shared by the stage registers, pc_reg and ctrl-side checks.
module stage_evt_decode
    import pipe_stage_reg_pkg::*;
(
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       s_up_i,
    input  logic       s_dn_i,
    output stage_evt_e evt_o
);

    // Reset beats flush beats stall; s_up=0 with s_dn=1 falls to advance
    always_comb begin
        evt_o = EVT_ADV;
        if (rst_i) begin
            evt_o = EVT_RST;
        end else if (flush_i) begin
            evt_o = EVT_FLUSH;
        end else if (s_up_i && !s_dn_i) begin
            evt_o = EVT_BUBBLE;
        end else if (s_up_i && s_dn_i) begin
            evt_o = EVT_HOLD;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic stage-boundary register: payload, valid, multi-cycle carry
// and a saturating consecutive-bubble counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = 128,
    parameter int unsigned       CARRY_W   = 66,
    parameter int unsigned       STALL_W   = 6,
    parameter int unsigned       STAGE_IDX = 3,
    parameter logic [DATA_W-1:0] NOP_DATA  = '0,
    parameter int unsigned       CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CARRY_W-1:0] carry_i,
    input  logic               bubble_cnt_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CARRY_W-1:0] carry_o,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_evt_e evt;

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    stage_evt_decode u_evt (
        .rst_i   (rst),
        .flush_i (flush),
        .s_up_i  (stall[STAGE_IDX]),
        .s_dn_i  (stall[STAGE_IDX+1]),
        .evt_o   (evt)
    );

    // Next-state selection per stage event; clear overrides count updates
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (evt)
            EVT_RST: begin
                valid_d = 1'b0;
                data_d  = NOP_DATA;
                carry_d = '0;
                cnt_d   = '0;
            end
            EVT_FLUSH: begin
                valid_d = 1'b0;
                data_d  = NOP_DATA;
                carry_d = '0;
            end
            EVT_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = NOP_DATA;
                carry_d = carry_i;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            EVT_ADV: begin
                valid_d = in_valid;
                data_d  = in_valid ? in_data : NOP_DATA;
                carry_d = '0;
                cnt_d   = '0;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
        if (bubble_cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_DATA;
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign carry_o    = carry_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: sequential vector table plus
// a counter saturation sequence on a narrow-counter instance.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 128;
    localparam int CARRY_W = 66;
    localparam int STALL_W = 6;

    localparam logic [5:0] S_ADV  = 6'b000000;
    localparam logic [5:0] S_BUB  = 6'b001111;
    localparam logic [5:0] S_HOLD = 6'b011111;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [CARRY_W-1:0] carry_i;
    logic               bubble_cnt_clr;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [CARRY_W-1:0] carry_o;
    logic [7:0]         bubble_cnt;

    logic               n_valid;
    logic [DATA_W-1:0]  n_data;
    logic [CARRY_W-1:0] n_carry;
    logic [1:0]         n_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .carry_i        (carry_i),
        .bubble_cnt_clr (bubble_cnt_clr),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .carry_o        (carry_o),
        .bubble_cnt     (bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_n (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .carry_i        (carry_i),
        .bubble_cnt_clr (bubble_cnt_clr),
        .out_valid      (n_valid),
        .out_data       (n_data),
        .carry_o        (n_carry),
        .bubble_cnt     (n_cnt)
    );

    // ctrl never produces upstream-running with downstream-stopped
    always @(posedge clk) begin
        if (!rst && !flush && !stall[3] && stall[4]) begin
            $error("illegal stall pair s_up=0 s_dn=1");
        end
    end

    typedef struct {
        logic               rst;
        logic               flush;
        logic [5:0]         stall;
        logic               in_valid;
        logic [DATA_W-1:0]  in_data;
        logic [CARRY_W-1:0] carry;
        logic               clr;
        logic               e_valid;
        logic [DATA_W-1:0]  e_data;
        logic [CARRY_W-1:0] e_carry;
        logic [7:0]         e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic r, input logic f, input logic [5:0] s,
        input logic iv, input logic [DATA_W-1:0] id,
        input logic [CARRY_W-1:0] c, input logic cl,
        input logic ev, input logic [DATA_W-1:0] ed,
        input logic [CARRY_W-1:0] ec, input logic [7:0] en
    );
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s;
        v.in_valid = iv; v.in_data = id; v.carry = c; v.clr = cl;
        v.e_valid = ev; v.e_data = ed; v.e_carry = ec; v.e_cnt = en;
        vecs.push_back(v);
    endtask

    task automatic check(
        input string name,
        input logic [DATA_W-1:0] got,
        input logic [DATA_W-1:0] exp
    );
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(
        input logic r, input logic f, input logic [5:0] s,
        input logic iv, input logic [DATA_W-1:0] id,
        input logic [CARRY_W-1:0] c, input logic cl
    );
        rst = r; flush = f; stall = s;
        in_valid = iv; in_data = id; carry_i = c; bubble_cnt_clr = cl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [CARRY_W-1:0] C1 = 66'h1_0000_0005_0000_0007;
    localparam logic [DATA_W-1:0]  DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0;
        in_data = '0; carry_i = '0; bubble_cnt_clr = 1'b0;

        //   rst flush stall  iv data     carry  clr  ev data    carry cnt
        add(1, 0, S_ADV,  1, DEAD,    0,     0,   0, 0,      0,    0);
        add(1, 0, S_ADV,  1, DEAD,    C1,    0,   0, 0,      0,    0);
        add(0, 0, S_ADV,  1, 'h1234,  0,     0,   1, 'h1234, 0,    0);
        add(0, 0, S_BUB,  1, 'h5555,  C1,    0,   0, 0,      C1,   1);
        add(0, 0, S_BUB,  1, 'h5555,  C1,    0,   0, 0,      C1,   2);
        add(0, 0, S_ADV,  1, 'hABCD,  C1,    0,   1, 'hABCD, 0,    0);
        add(0, 0, S_BUB,  1, 'h1111,  'h99,  0,   0, 0,      'h99, 1);
        add(0, 0, S_HOLD, 1, 'h7777,  0,     0,   0, 0,      'h99, 1);
        add(0, 0, S_HOLD, 1, 'h8888,  'h5,   0,   0, 0,      'h99, 1);
        add(0, 0, S_ADV,  1, 'h4242,  0,     0,   1, 'h4242, 0,    0);
        add(0, 0, S_HOLD, 0, 'h9999,  'h7,   0,   1, 'h4242, 0,    0);
        add(0, 0, S_HOLD, 1, 'hAAAA,  'h8,   0,   1, 'h4242, 0,    0);
        add(0, 0, S_BUB,  1, 'h1,     'h55,  0,   0, 0,      'h55, 1);
        add(0, 1, S_BUB,  1, 'h2,     'h77,  0,   0, 0,      0,    1);
        add(0, 0, S_BUB,  1, 'h3,     'h33,  0,   0, 0,      'h33, 2);
        add(0, 1, S_BUB,  1, 'h4,     'h44,  1,   0, 0,      0,    0);
        add(0, 0, S_ADV,  0, 'hBEEF,  'h9,   0,   0, 0,      0,    0);
        add(0, 0, S_BUB,  1, 'h5,     'h11,  0,   0, 0,      'h11, 1);
        add(0, 0, S_BUB,  1, 'h6,     'h22,  1,   0, 0,      'h22, 0);
        add(0, 0, S_BUB,  1, 'h7,     'h23,  0,   0, 0,      'h23, 1);
        add(0, 0, S_HOLD, 1, 'h8,     'h24,  1,   0, 0,      'h23, 0);
        add(0, 0, S_ADV,  1, 'h9,     0,     0,   1, 'h9,    0,    0);
        add(0, 1, S_ADV,  1, 'hA,     'h1,   0,   0, 0,      0,    0);
        add(0, 0, S_ADV,  1, 'h1,     0,     0,   1, 'h1,    0,    0);
        add(0, 0, S_BUB,  1, 'h2,     'h66,  0,   0, 0,      'h66, 1);
        add(1, 0, S_BUB,  1, 'h3,     'h66,  0,   0, 0,      0,    0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].stall,
                  vecs[i].in_valid, vecs[i].in_data,
                  vecs[i].carry, vecs[i].clr);
            check($sformatf("v%0d.valid", i), DATA_W'(out_valid),
                  DATA_W'(vecs[i].e_valid));
            check($sformatf("v%0d.data", i), out_data, vecs[i].e_data);
            check($sformatf("v%0d.carry", i), DATA_W'(carry_o),
                  DATA_W'(vecs[i].e_carry));
            check($sformatf("v%0d.cnt", i), DATA_W'(bubble_cnt),
                  DATA_W'(vecs[i].e_cnt));
        end

        // Narrow counter saturates at 3; wide counter keeps counting
        drive(1, 0, S_ADV, 0, 0, 0, 0);
        check("sat.reset", DATA_W'(n_cnt), 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, S_BUB, 1, DATA_W'(k), CARRY_W'(k), 0);
            check($sformatf("sat.n%0d", k), DATA_W'(n_cnt),
                  DATA_W'((k > 3) ? 3 : k));
            check($sformatf("sat.w%0d", k), DATA_W'(bubble_cnt),
                  DATA_W'(k));
            check($sformatf("sat.carry%0d", k), DATA_W'(n_carry),
                  DATA_W'(k));
        end
        drive(0, 0, S_HOLD, 1, 'h55, 0, 0);
        check("sat.hold", DATA_W'(n_cnt), 3);
        drive(0, 0, S_ADV, 1, 'h77, 0, 0);
        check("sat.adv_cnt", DATA_W'(n_cnt), 0);
        check("sat.adv_data", n_data, 'h77);
        check("sat.adv_valid", DATA_W'(n_valid), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
